// File: rtl/serial_fsub.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, LSB first.
// Ports: clk, rst (async, active-high), start/a/b/bin in; busy/done/diff/bout out.
// Optional: define SERIAL_FSUB_OVF_EN to add the ovf (signed overflow) output.
module serial_fsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_FSUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
`ifdef SERIAL_FSUB_OVF_EN
  logic             r_ovf;
`endif

  logic w_x;
  logic w_y;
  logic w_d;
  logic w_br_nx;
  logic w_last;

  // Full-subtractor cell on the current LSBs.
  assign w_x     = r_sa[0];
  assign w_y     = r_sb[0];
  assign w_d     = w_x ^ w_y ^ r_br;
  assign w_br_nx = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
  assign w_last  = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_br    <= 1'b0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef SERIAL_FSUB_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa    <= a;
            r_sb    <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_br  <= w_br_nx;
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_bout  <= w_br_nx;
`ifdef SERIAL_FSUB_OVF_EN
            // On the last bit w_x/w_y are the operand sign bits
            // and w_d is the result sign bit.
            r_ovf   <= (w_x ^ w_y) & (w_d ^ w_x);
`endif
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_res;
  assign bout = r_bout;
`ifdef SERIAL_FSUB_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_fsub.sv
// Self-checking bench for serial_fsub (WIDTH=8): directed and random
// operations compared against an arithmetic reference model.
module tb_serial_fsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_FSUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_done = -1;

  serial_fsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_FSUB_OVF_EN
    .ovf   (ovf),
`endif
    .bout  (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 9-bit unsigned and integer signed arithmetic.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       input logic mbi, output logic [W-1:0] md,
                       output logic mbo, output logic mov);
    logic [W:0] full;
    int         s;
    full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbi};
    md   = full[W-1:0];
    mbo  = full[W];
    s    = $signed(ma) - $signed(mb) - int'(mbi);
    mov  = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_diff"}, 32'(diff), 32'h0);
    check({tag, "_bout"}, 32'(bout), 32'h0);
`ifdef SERIAL_FSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
`endif
  endtask

  // Starts on an IDLE-cycle negedge, ends on the DONE-cycle negedge.
  // poke: RUN cycle (1..W) in which start is pulsed with junk operands.
  task automatic run_op(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb, input logic tbi,
                        input int poke, input bit hold, input bit per);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    model(ta, tb, tbi, ed, eb, eo);
    @(negedge clk);
    check({tag, "_idle_busy"}, 32'(busy), 32'h0);
    check({tag, "_idle_done"}, 32'(done), 32'h0);
    a = ta;
    b = tb;
    bin = tbi;
    start = 1'b1;
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      start = hold | (i == poke);
      a = W'($urandom);
      b = W'($urandom);
      bin = 1'($urandom);
      check({tag, "_run_busy"}, 32'(busy), 32'h1);
      check({tag, "_run_done"}, 32'(done), 32'h0);
    end
    @(negedge clk);
    start = hold;
    check({tag, "_done"}, 32'(done), 32'h1);
    check({tag, "_dbusy"}, 32'(busy), 32'h0);
    check({tag, "_diff"}, 32'(diff), 32'(ed));
    check({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_FSUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
    if (per && last_done >= 0)
      check({tag, "_period"}, 32'(cyc - last_done), 32'(W + 2));
    last_done = cyc;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_op("basic", 8'h5A, 8'h3C, 1'b0, 0, 1'b0, 1'b0);
    run_op("wrap", 8'h00, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op("bin1", 8'h10, 8'h0F, 1'b1, 0, 1'b0, 1'b0);
    run_op("bin2", 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0);
    run_op("ovf1", 8'h80, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    run_op("ovf2", 8'h7F, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    run_op("ovf3", 8'h00, 8'h80, 1'b1, 0, 1'b0, 1'b0);
    run_op("poke", 8'h20, 8'h01, 1'b0, 3, 1'b0, 1'b0);
    @(negedge clk);
    check("poke_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("poke_stay_idle", 32'(busy), 32'h0);

    last_done = -1;
    for (int k = 0; k < 3; k++)
      run_op("b2b", W'($urandom), W'($urandom), 1'($urandom), 0, 1'b1, 1'b1);
    start = 1'b0;

    @(negedge clk);
    a = 8'h11;
    b = 8'h22;
    start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_pre", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk);
    check_zero("abort_hold");
    rst = 1'b0;
    run_op("post", 8'h03, 8'h05, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 20; k++)
      run_op("rand", W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, W)), 1'b0, 1'b0);
    @(negedge clk);
    check("end_done", 32'(done), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
